softusb_dmem_arb: RTL and testbench
===================================

SOFTUSB_DMEM_ARB -- requirements
Module: softusb_dmem_arb

Interface
REQ-001 SHALL have parameter DMEM_WIDTH, default 13: data memory address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, legal range 0..15: maximum cycles a pending DMA request waits behind the CPU.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports cpu_en in 1, CPU accesses memory this cycle; cpu_we in 1, CPU write; cpu_a in DMEM_WIDTH, CPU address; cpu_do in 8, CPU write data.
REQ-006 SHALL have ports cpu_di out 8, CPU read data; cpu_stall out 1, CPU access not performed and held by the CPU.
REQ-007 SHALL have ports dma_req in 1, DMA access request; dma_we in 1, DMA write; dma_a in DMEM_WIDTH, DMA address; dma_do in 8, DMA write data.
REQ-008 SHALL have ports dma_ack out 1, DMA access performed this cycle; dma_di out 8, DMA read data; dma_rvalid out 1, dma_di valid.
REQ-009 SHALL have ports mem_we out 1, mem_a out DMEM_WIDTH, mem_do out 8 to a synchronous single-port RAM, and mem_di in 8, RAM read data valid the cycle after the address.
REQ-010 SHALL have port steal_cnt out 16, saturating count of forced DMA grants.

Function
REQ-011 SHALL have exactly one owner of the RAM port per cycle; mem_a/mem_we/mem_do driven combinationally from the owner.
REQ-012 SHALL grant DMA (dma_owns) when dma_req=1 and (cpu_en=0 or wait_cnt==MAX_WAIT); otherwise the CPU owns.
REQ-013 SHALL, when DMA owns: mem_a=dma_a, mem_do=dma_do, mem_we=dma_we, dma_ack=1, cpu_stall=cpu_en.
REQ-014 SHALL, when CPU owns: mem_a=cpu_a, mem_do=cpu_do, mem_we=cpu_en&cpu_we, dma_ack=0, cpu_stall=0.
REQ-015 SHALL, when neither requests, drive mem_a=cpu_a, mem_we=0.
REQ-016 SHALL keep 4-bit wait_cnt: cleared when dma_req=0 or dma_ack=1; else incremented, saturating at MAX_WAIT.
REQ-017 SHALL with MAX_WAIT=0 grant DMA on every cycle dma_req=1.
REQ-018 SHALL guarantee after a forced grant (cpu_en=1 and dma_ack=1) at least MAX_WAIT following CPU-owned cycles before the next forced grant, given continuous cpu_en.
REQ-019 SHALL register dma_rvalid=1 exactly one cycle after a cycle with dma_ack=1 and dma_we=0; 0 otherwise.
REQ-020 SHALL drive dma_di=mem_di and cpu_di=mem_di combinationally; CPU read data valid the cycle after a non-stalled CPU read.
REQ-021 SHALL increment steal_cnt by 1 on each forced grant, saturating at 16'hFFFF.
REQ-022 SHALL not buffer a stalled CPU access; the CPU presents it again next cycle.
REQ-023 SHALL on same-address DMA write and stalled CPU write commit DMA data first, then CPU data the next cycle (CPU value final).
REQ-024 SHALL treat dma_req dropped while waiting as cancelled; no ack, wait_cnt cleared.

Reset
REQ-025 SHALL, while rst=1, force dma_ack=0, cpu_stall=0, mem_we=0 combinationally.
REQ-026 SHALL on a rising edge with rst=1 set wait_cnt=0, dma_rvalid=0, steal_cnt=0.
REQ-027 SHALL, on reset asserted mid-DMA-read, produce no dma_rvalid pulse after the reset cycle.

Verification
REQ-028 SHALL cover: cpu_en=0, dma_req=1 read of 0x0100 holding 0x5A -> dma_ack same cycle, dma_rvalid=1 and dma_di=0x5A next cycle, cpu_stall=0.
REQ-029 SHALL cover: cpu_en=1 continuous, dma_req=1 continuous, MAX_WAIT=4 -> dma_ack on cycles 5,10,15 relative to request start, cpu_stall=1 only those cycles, steal_cnt=3.
REQ-030 SHALL cover: MAX_WAIT=0, cpu_en=1, dma_req=1 -> dma_ack and cpu_stall every cycle, steal_cnt counts each cycle.
REQ-031 SHALL cover: forced grant, DMA writes 0x11 and CPU writes 0x22 to 0x0042 -> RAM at 0x0042 reads 0x22 after both.
REQ-032 SHALL cover: dma_req held 2 cycles under cpu_en=1 then dropped -> no dma_ack, wait_cnt 0, re-request waits full MAX_WAIT again.
REQ-033 SHALL cover: rst=1 asserted the cycle after a DMA read ack -> dma_rvalid=0, steal_cnt=0, mem_we=0 during reset.

Source files
------------

// File: rtl/softusb_dmem_arb.sv
// Data-memory arbiter: CPU normally owns the single RAM port; DMA takes idle
// cycles and forces a steal after MAX_WAIT cycles of waiting behind the CPU.
module softusb_dmem_arb #(
    parameter int DMEM_WIDTH = 13,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_en,
    input  logic                  cpu_we,
    input  logic [DMEM_WIDTH-1:0] cpu_a,
    input  logic [7:0]            cpu_do,
    output logic [7:0]            cpu_di,
    output logic                  cpu_stall,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DMEM_WIDTH-1:0] dma_a,
    input  logic [7:0]            dma_do,
    output logic                  dma_ack,
    output logic [7:0]            dma_di,
    output logic                  dma_rvalid,

    output logic                  mem_we,
    output logic [DMEM_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_do,
    input  logic [7:0]            mem_di,

    output logic [15:0]           steal_cnt
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       dma_owns;
    logic       forced;
    logic       rvalid_q;

    assign dma_owns  = dma_req & (~cpu_en | (wait_cnt == WAIT_LIMIT));
    assign dma_ack   = dma_owns & ~rst;
    assign forced    = dma_ack & cpu_en;
    assign cpu_stall = forced;

    always_comb begin
        mem_a  = cpu_a;
        mem_do = cpu_do;
        mem_we = 1'b0;
        if (!rst) begin
            if (dma_owns) begin
                mem_a  = dma_a;
                mem_do = dma_do;
                mem_we = dma_we;
            end else begin
                mem_we = cpu_en & cpu_we;
            end
        end else if (dma_owns) begin
            mem_a  = dma_a;
            mem_do = dma_do;
        end
    end

    assign cpu_di = mem_di;
    assign dma_di = mem_di;

    // Masking with rst kills a read-data pulse left over from an ack taken just before reset.
    assign dma_rvalid = rvalid_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            rvalid_q  <= 1'b0;
            steal_cnt <= 16'd0;
        end else begin
            if (!dma_req || dma_ack)
                wait_cnt <= 4'd0;
            else if (wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + 4'd1;
            rvalid_q <= dma_ack & ~dma_we;
            if (forced && steal_cnt != 16'hFFFF)
                steal_cnt <= steal_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_softusb_dmem_arb.sv
// Bench for softusb_dmem_arb: expected DMA acks and read data are queued by the
// stimulus and consumed by a negedge monitor; a small RAM model backs the port.
module tb_softusb_dmem_arb;

    logic        clk;
    logic        rst;
    int          cyc;
    int          checks;
    int          errors;

    logic        a_cpu_en, a_cpu_we, a_dma_req, a_dma_we;
    logic [12:0] a_cpu_a, a_dma_a;
    logic [7:0]  a_cpu_do, a_dma_do;
    logic [7:0]  a_cpu_di, a_dma_di, a_mem_do, a_mem_di;
    logic        a_cpu_stall, a_dma_ack, a_dma_rvalid, a_mem_we;
    logic [12:0] a_mem_a;
    logic [15:0] a_steal_cnt;

    logic        b_cpu_en, b_cpu_we, b_dma_req, b_dma_we;
    logic [12:0] b_cpu_a, b_dma_a;
    logic [7:0]  b_cpu_do, b_dma_do;
    logic [7:0]  b_cpu_di, b_dma_di, b_mem_do, b_mem_di;
    logic        b_cpu_stall, b_dma_ack, b_dma_rvalid, b_mem_we;
    logic [12:0] b_mem_a;
    logic [15:0] b_steal_cnt;

    logic [7:0]  ram [0:8191];

    typedef struct {
        int         at;
        logic [7:0] data;
    } rv_t;

    int  ack_q[$];
    rv_t rv_q[$];

    softusb_dmem_arb #(.DMEM_WIDTH(13), .MAX_WAIT(4)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_en(a_cpu_en), .cpu_we(a_cpu_we), .cpu_a(a_cpu_a), .cpu_do(a_cpu_do),
        .cpu_di(a_cpu_di), .cpu_stall(a_cpu_stall),
        .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_a(a_dma_a), .dma_do(a_dma_do),
        .dma_ack(a_dma_ack), .dma_di(a_dma_di), .dma_rvalid(a_dma_rvalid),
        .mem_we(a_mem_we), .mem_a(a_mem_a), .mem_do(a_mem_do), .mem_di(a_mem_di),
        .steal_cnt(a_steal_cnt)
    );

    softusb_dmem_arb #(.DMEM_WIDTH(13), .MAX_WAIT(0)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_en(b_cpu_en), .cpu_we(b_cpu_we), .cpu_a(b_cpu_a), .cpu_do(b_cpu_do),
        .cpu_di(b_cpu_di), .cpu_stall(b_cpu_stall),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_a(b_dma_a), .dma_do(b_dma_do),
        .dma_ack(b_dma_ack), .dma_di(b_dma_di), .dma_rvalid(b_dma_rvalid),
        .mem_we(b_mem_we), .mem_a(b_mem_a), .mem_do(b_mem_do), .mem_di(b_mem_di),
        .steal_cnt(b_steal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (a_mem_we) ram[a_mem_a] <= a_mem_do;
        a_mem_di <= ram[a_mem_a];
    end

    always @(negedge clk) begin
        bit ea;
        bit er;
        ea = (ack_q.size() > 0) && (ack_q[0] == cyc);
        er = (rv_q.size() > 0) && (rv_q[0].at == cyc);
        checks++;
        if (a_dma_ack !== ea) begin
            errors++;
            $display("FAIL dma_ack cyc=%0d got %b expected %b", cyc, a_dma_ack, ea);
        end
        checks++;
        if (a_cpu_stall !== (ea && a_cpu_en)) begin
            errors++;
            $display("FAIL cpu_stall cyc=%0d got %b expected %b", cyc, a_cpu_stall, ea && a_cpu_en);
        end
        if (ea) void'(ack_q.pop_front());
        checks++;
        if (a_dma_rvalid !== er) begin
            errors++;
            $display("FAIL dma_rvalid cyc=%0d got %b expected %b", cyc, a_dma_rvalid, er);
        end
        if (er) begin
            checks++;
            if (a_dma_di !== rv_q[0].data) begin
                errors++;
                $display("FAIL dma_di cyc=%0d got %h expected %h", cyc, a_dma_di, rv_q[0].data);
            end
            void'(rv_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic a_idle();
        a_cpu_en = 0; a_cpu_we = 0; a_cpu_a = '0; a_cpu_do = '0;
        a_dma_req = 0; a_dma_we = 0; a_dma_a = '0; a_dma_do = '0;
    endtask

    task automatic a_dma(input logic we, input logic [12:0] addr, input logic [7:0] data);
        a_dma_req = 1; a_dma_we = we; a_dma_a = addr; a_dma_do = data;
    endtask

    task automatic a_cpu(input logic we, input logic [12:0] addr, input logic [7:0] data);
        a_cpu_en = 1; a_cpu_we = we; a_cpu_a = addr; a_cpu_do = data;
    endtask

    initial begin
        int c;
        cyc = 0; checks = 0; errors = 0;
        b_cpu_a = '0; b_cpu_do = '0; b_dma_a = 13'h10; b_dma_do = '0; b_mem_di = 8'h00;
        b_cpu_we = 0; b_dma_we = 0;

        // Reset with every request asserted: no grants, no writes.
        rst = 1;
        a_cpu(1, 13'h042, 8'hEE); a_dma(1, 13'h042, 8'hDD);
        b_cpu_en = 1; b_dma_req = 1;
        nxt();
        @(negedge clk);
        chk("rst_mem_we", 32'(a_mem_we), 0);
        chk("rst_b_ack", 32'(b_dma_ack), 0);
        chk("rst_b_stall", 32'(b_cpu_stall), 0);
        nxt();
        rst = 0; a_idle(); b_cpu_en = 0; b_dma_req = 0;
        chk("rst_steal", 32'(a_steal_cnt), 0);

        // Idle-cycle DMA write preloads 0x0100.
        nxt(); a_dma(1, 13'h100, 8'h5A); ack_q.push_back(cyc);
        nxt(); a_idle();

        // DMA read with CPU idle: ack now, data next cycle.
        nxt(); a_dma(0, 13'h100, 8'h00); ack_q.push_back(cyc);
        rv_q.push_back('{cyc + 1, 8'h5A});
        nxt(); a_idle();

        // Continuous contention: steals at request cycles 5, 10, 15.
        nxt(); c = cyc;
        a_cpu(0, 13'h000, 8'h00); a_dma(1, 13'h200, 8'h77);
        ack_q.push_back(c + 4); ack_q.push_back(c + 9); ack_q.push_back(c + 14);
        repeat (14) nxt();
        nxt(); a_idle();
        chk("steal_after_3", 32'(a_steal_cnt), 3);

        // Request dropped after two cycles is cancelled; re-request waits in full.
        nxt(); c = cyc;
        a_cpu(0, 13'h000, 8'h00); a_dma(1, 13'h201, 8'h66);
        nxt();
        nxt(); a_dma_req = 0;
        nxt(); a_dma_req = 1; ack_q.push_back(c + 7);
        repeat (4) nxt();
        nxt(); a_idle();
        chk("steal_after_cancel", 32'(a_steal_cnt), 4);

        // Same-address collision: DMA 0x11 lands first, replayed CPU 0x22 wins.
        nxt(); c = cyc;
        a_cpu(1, 13'h043, 8'h33); a_dma(1, 13'h042, 8'h11);
        ack_q.push_back(c + 4);
        repeat (3) nxt();
        nxt(); a_cpu(1, 13'h042, 8'h22);
        nxt(); a_dma_req = 0;
        chk("ram42_dma_first", 32'(ram[13'h042]), 32'h11);
        nxt(); a_cpu_en = 0; a_cpu_we = 0;
        chk("ram42_cpu_final", 32'(ram[13'h042]), 32'h22);
        a_dma(0, 13'h042, 8'h00); ack_q.push_back(cyc);
        rv_q.push_back('{cyc + 1, 8'h22});
        nxt(); a_dma_req = 0; a_cpu(0, 13'h043, 8'h00);
        nxt(); a_idle();
        chk("cpu_read_43", 32'(a_cpu_di), 32'h33);
        chk("steal_after_collision", 32'(a_steal_cnt), 5);

        // Reset right after a DMA read ack: no read-data pulse, counters cleared.
        nxt(); a_dma(0, 13'h100, 8'h00); ack_q.push_back(cyc);
        nxt(); rst = 1; a_cpu(1, 13'h050, 8'h99); a_dma(1, 13'h051, 8'h98);
        @(negedge clk);
        chk("rst_mid_mem_we", 32'(a_mem_we), 0);
        chk("rst_mid_rvalid", 32'(a_dma_rvalid), 0);
        nxt();
        nxt(); rst = 0; a_idle();
        chk("rst_mid_steal", 32'(a_steal_cnt), 0);
        nxt();
        nxt();

        // MAX_WAIT=0: DMA wins every requested cycle, each one a steal.
        nxt(); b_cpu_en = 1; b_cpu_we = 0; b_dma_req = 1; b_dma_we = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_ack", 32'(b_dma_ack), 1);
            chk("b_stall", 32'(b_cpu_stall), 1);
            chk("b_steal", 32'(b_steal_cnt), 32'(i));
            if (i > 0) chk("b_rvalid", 32'(b_dma_rvalid), 1);
            nxt();
        end
        b_dma_req = 0;
        chk("b_steal_final", 32'(b_steal_cnt), 5);
        @(negedge clk);
        chk("b_ack_off", 32'(b_dma_ack), 0);
        chk("b_stall_off", 32'(b_cpu_stall), 0);
        nxt(); b_cpu_en = 0;
        nxt();

        checks++;
        if (ack_q.size() != 0 || rv_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got ack=%0d rv=%0d expected 0", ack_q.size(), rv_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
